// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_pkg                                                      |
// | Description : Shared AHB-Lite encodings (HTRANS/HBURST/HSIZE/HRESP), the   |
// |               SRAM slave FSM state encoding and a byte-strobe helper.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // Byte-lane enable for one transfer; sizes above a word fall back to all lanes.
  function automatic logic [3:0] ahb_strobe(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << a;
      HSIZE_HALF: s = 4'b0011 << {a[1], 1'b0};
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_array                                               |
// | Description : DEPTH x 32 word storage, asynchronous read, synchronous      |
// |               write with per-byte enable. Contents are never reset.        |
// | Revision    : 1.0  initial release                                         |
// | Ports       : clk      in   clock                                          |
// |               we_i     in   write enable                                   |
// |               be_i     in   4-bit byte enable                              |
// |               addr_i   in   word index                                     |
// |               wdata_i  in   write data                                     |
// |               rdata_o  out  read data (combinational from addr_i)          |
// +----------------------------------------------------------------------------+
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_slave                                               |
// | Description : AHB-Lite slave in front of a word-organised SRAM. Beat-based |
// |               (bursts served one beat at a time), programmable wait        |
// |               states, byte/halfword/word lanes.                            |
// |               Optional macro AHB_SLV_ERR_RESP_EN: two-cycle ERROR response |
// |               for out-of-range, misaligned or oversized accesses. Without  |
// |               it addresses alias modulo MEM_DEPTH*4 and hresp is OKAY.     |
// | Revision    : 1.0  initial release                                         |
// | Ports       : hclk/hresetn (async active-low), hsel_i, haddr_i, htrans_i,  |
// |               hwrite_i, hsize_i, hburst_i, hprot_i, hmastlock_i, hwdata_i, |
// |               hready_i -> hreadyout_o, hrdata_o, hresp_o                   |
// +----------------------------------------------------------------------------+
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic                  hmastlock_i,
  input  logic [31:0]           hwdata_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic [31:0]           hrdata_o,
  output logic [1:0]            hresp_o
);

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             write_q, write_d;
  logic [3:0]       strb_q, strb_d;

  logic             w_accept;
  logic             w_err;
  logic             w_we;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Burst type, protection, lock and the SEQ/NONSEQ distinction do not matter
  // to a beat-based slave; upper address bits only matter for error checking.
  assign w_unused = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0], haddr_i};

  assign w_accept = hsel_i & hready_i & htrans_i[1];

`ifdef AHB_SLV_ERR_RESP_EN
  always_comb begin
    w_err = 1'b0;
    if (haddr_i[ADDR_WIDTH-1:IDX_W+2] != '0)                w_err = 1'b1;
    if ((hsize_i == HSIZE_HALF) && haddr_i[0])              w_err = 1'b1;
    if ((hsize_i == HSIZE_WORD) && (haddr_i[1:0] != 2'b00)) w_err = 1'b1;
    if (hsize_i > HSIZE_WORD)                               w_err = 1'b1;
  end
`else
  assign w_err = 1'b0;
`endif

  // Address-phase capture; the strobe already encodes size and low address bits.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    if (w_accept) begin
      addr_d  = haddr_i[IDX_W+1:2];
      write_d = hwrite_i;
      strb_d  = ahb_strobe(hsize_i, haddr_i[1:0]);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      strb_q  <= strb_d;
    end
  end

  // Next state. IDLE, DATA and ERR2 all have hreadyout high, so each of them
  // may take a new address phase and pipeline straight into the next beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (w_accept) begin
          if (w_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    hrdata_o    = '0;
    w_we        = 1'b0;
    case (state_q)
      ST_WAIT: hreadyout_o = 1'b0;
      ST_DATA: begin
        hrdata_o = w_rdata;
        w_we     = write_q;
      end
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      ST_ERR2: hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  // Write lands at the edge closing DATA, so a read beat right behind it
  // already sees the new word through the asynchronous read port.
  ahb_sram_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (hclk),
    .we_i    (w_we),
    .be_i    (strb_q),
    .addr_i  (addr_q),
    .wdata_i (hwdata_i),
    .rdata_o (w_rdata)
  );

endmodule
`default_nettype wire
